// File: rtl/dma_priority_resolver_pkg.sv
// Shared types and constants for the 8237A-style DMA priority resolver.
// Imported by the encoder, the checker and the resolver top.
package dma_pkg;

    localparam int NUM_CH = 4;

    // Bit positions of the resolver controls inside the command register
    localparam int CMD_CTRL_DIS   = 2;
    localparam int CMD_ROT        = 4;
    localparam int CMD_DREQ_SENSE = 6;
    localparam int CMD_DACK_SENSE = 7;

    typedef logic [1:0] chan_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] chan_onehot(input chan_t ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/dma_priority_resolver_chk.sv
// Structural invariants of the resolver outputs, kept apart from the datapath.
// Only evaluated when the design is elaborated with assertions enabled.
module dma_priority_resolver_chk
    import dma_pkg::*;
(
    input logic              clk,
    input logic              reset,
    input logic [NUM_CH-1:0] valid,
    input logic [NUM_CH-1:0] dack_active,
    input logic              busy
);

    // Requests and acknowledges never name more than one channel
    a_valid_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(valid));
    a_dack_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(dack_active));

    // An acknowledge is only ever given to the channel being presented
    a_dack_matches: assert property (@(posedge clk) disable iff (reset)
        (dack_active == 4'b0000) || (dack_active == valid));
    a_busy_valid: assert property (@(posedge clk) disable iff (reset)
        busy == (valid != 4'b0000));

endmodule

// File: rtl/dma_priority_resolver_encoder.sv
// Combinational priority encoder: the search starts one past last_svc and wraps,
// so fixed priority is obtained by presenting last_svc = 3.
module dma_prio_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] eff,
    input  chan_t             last_svc,
    output chan_t             winner,
    output logic              valid
);

    logic [NUM_CH-1:0] rot_s;
    chan_t             offset_s;
    chan_t             idx_s;

    // Rotate requests so bit 0 is the highest-priority channel, then encode
    always_comb begin
        rot_s    = 4'b0000;
        idx_s    = 2'd0;
        offset_s = 2'd0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx_s    = chan_t'(j) + last_svc + 2'd1;
            rot_s[j] = eff[idx_s];
        end
        casez (rot_s)
            4'b???1: offset_s = 2'd0;
            4'b??10: offset_s = 2'd1;
            4'b?100: offset_s = 2'd2;
            4'b1000: offset_s = 2'd3;
            default: offset_s = 2'd0;
        endcase
        winner = last_svc + 2'd1 + offset_s;
        valid  = |eff;
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA priority resolver: synchronizes DREQ pins, forms effective requests,
// arbitrates (fixed/rotating), and hands the winner to timing control.
module dma_priority_resolver
    import dma_pkg::*;
#(
    parameter int DREQ_SYNC_STAGES = 2,
    parameter int SOFTREQ_EN       = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] softReq,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              dreqSense,
    input  logic              dackSense,
    input  logic              rotPriority,
    input  logic              ctrlDisable,
    input  logic              hrq,
    input  logic              validDACK,
    output logic              VALID_DREQ0,
    output logic              VALID_DREQ1,
    output logic              VALID_DREQ2,
    output logic              VALID_DREQ3,
    output logic [NUM_CH-1:0] DACK,
    output chan_t             activeCh,
    output logic              busy
);

    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] soft_s;
    logic [NUM_CH-1:0] eff_s;
    chan_t             prio_base_s;
    chan_t             enc_winner_s;
    logic              enc_valid_s;

    state_t            state_r, state_n;
    chan_t             winner_r, winner_n;
    chan_t             last_svc_r, last_svc_n;
    logic [NUM_CH-1:0] valid_r, valid_n;
    logic [NUM_CH-1:0] dack_active_r, dack_active_n;
    logic              busy_r, busy_n;

    generate
        if (DREQ_SYNC_STAGES == 0) begin : g_no_sync
            assign sync_s = DREQ;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_r [DREQ_SYNC_STAGES];

            // Pin synchronizer chain; cleared by reset so stale pins cannot win
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    for (int i = 0; i < DREQ_SYNC_STAGES; i++) begin
                        sync_r[i] <= 4'b0000;
                    end
                end else begin
                    sync_r[0] <= DREQ;
                    for (int i = 1; i < DREQ_SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign sync_s = sync_r[DREQ_SYNC_STAGES-1];
        end
    endgenerate

    // Effective requests: software requests skip both the mask and the synchronizer
    always_comb begin
        soft_s = (SOFTREQ_EN != 0) ? softReq : 4'b0000;
        if (ctrlDisable) begin
            eff_s = 4'b0000;
        end else begin
            eff_s = ((sync_s ^ {NUM_CH{dreqSense}}) & ~maskReg) | soft_s;
        end
        prio_base_s = rotPriority ? last_svc_r : 2'd3;
    end

    dma_prio_encoder u_encoder (
        .eff      (eff_s),
        .last_svc (prio_base_s),
        .winner   (enc_winner_s),
        .valid    (enc_valid_s)
    );

    // Next-state and next-output logic of the arbitration FSM
    always_comb begin
        state_n       = state_r;
        winner_n      = winner_r;
        last_svc_n    = last_svc_r;
        valid_n       = valid_r;
        dack_active_n = dack_active_r;
        case (state_r)
            ST_IDLE: begin
                if (enc_valid_s) begin
                    state_n  = ST_REQ;
                    winner_n = enc_winner_s;
                    valid_n  = chan_onehot(enc_winner_s);
                end else begin
                    valid_n       = 4'b0000;
                    dack_active_n = 4'b0000;
                end
            end
            ST_REQ: begin
                // A grant outranks a withdrawal seen in the same cycle
                if (hrq && validDACK) begin
                    state_n       = ST_SERVICE;
                    dack_active_n = chan_onehot(winner_r);
                end else if (!eff_s[winner_r]) begin
                    state_n = ST_IDLE;
                    valid_n = 4'b0000;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (!validDACK) begin
                    state_n       = ST_IDLE;
                    valid_n       = 4'b0000;
                    dack_active_n = 4'b0000;
                    if (rotPriority) begin
                        last_svc_n = winner_r;
                    end else begin
                        last_svc_n = last_svc_r;
                    end
                end else begin
                    state_n = ST_SERVICE;
                end
            end
            default: begin
                state_n       = ST_IDLE;
                valid_n       = 4'b0000;
                dack_active_n = 4'b0000;
            end
        endcase
        if (state_n != ST_IDLE) begin
            busy_n = 1'b1;
        end else begin
            busy_n = 1'b0;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            winner_r      <= 2'd0;
            last_svc_r    <= 2'd3;
            valid_r       <= 4'b0000;
            dack_active_r <= 4'b0000;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            winner_r      <= winner_n;
            last_svc_r    <= last_svc_n;
            valid_r       <= valid_n;
            dack_active_r <= dack_active_n;
            busy_r        <= busy_n;
        end
    end

    assign VALID_DREQ0 = valid_r[0];
    assign VALID_DREQ1 = valid_r[1];
    assign VALID_DREQ2 = valid_r[2];
    assign VALID_DREQ3 = valid_r[3];
    assign DACK        = dack_active_r ^ {NUM_CH{~dackSense}};
    assign activeCh    = winner_r;
    assign busy        = busy_r;

    dma_priority_resolver_chk u_chk (
        .clk         (CLK),
        .reset       (RESET),
        .valid       (valid_r),
        .dack_active (dack_active_r),
        .busy        (busy_r)
    );

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver: a per-edge behavioural model is
// compared every cycle, plus literal expectations at the key scenario points.
module tb_dma_priority_resolver;

    localparam int SYNC = 2;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ, softReq, maskReg;
    logic       dreqSense, dackSense, rotPriority, ctrlDisable, hrq, validDACK;
    logic       VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3;
    logic [3:0] DACK;
    logic [1:0] activeCh;
    logic       busy;
    logic [3:0] dut_valid;

    int total = 0;
    int bad   = 0;

    dma_priority_resolver #(.DREQ_SYNC_STAGES(SYNC), .SOFTREQ_EN(1)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .softReq(softReq), .maskReg(maskReg),
        .dreqSense(dreqSense), .dackSense(dackSense), .rotPriority(rotPriority),
        .ctrlDisable(ctrlDisable), .hrq(hrq), .validDACK(validDACK),
        .VALID_DREQ0(VALID_DREQ0), .VALID_DREQ1(VALID_DREQ1),
        .VALID_DREQ2(VALID_DREQ2), .VALID_DREQ3(VALID_DREQ3),
        .DACK(DACK), .activeCh(activeCh), .busy(busy)
    );

    assign dut_valid = {VALID_DREQ3, VALID_DREQ2, VALID_DREQ1, VALID_DREQ0};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // phase: 0 = nothing presented, 1 = request presented, 2 = being serviced
    int         m_phase  = 0;
    int         m_win    = 0;
    int         m_last   = 3;
    int         m_active = 0;
    logic [3:0] pin_hist[$];

    function automatic logic [3:0] model_eff();
        logic [3:0] pins;
        logic [3:0] e;
        pins = pin_hist[0];
        e = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            e[i] = ((pins[i] ^ dreqSense) & ~maskReg[i]) | softReq[i];
        end
        if (ctrlDisable) e = 4'b0000;
        return e;
    endfunction

    function automatic int model_pick(input logic [3:0] e, input int base);
        for (int k = 1; k <= 4; k++) begin
            int ch;
            ch = (base + k) % 4;
            if (e[ch]) return ch;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [3:0] e;
        if (RESET) begin
            m_phase = 0; m_last = 3; m_active = 0; m_win = 0;
            pin_hist.delete();
            for (int i = 0; i < SYNC; i++) pin_hist.push_back(4'b0000);
        end else begin
            e = model_eff();
            if (m_phase == 0) begin
                if (e != 4'b0000) begin
                    m_win = model_pick(e, rotPriority ? m_last : 3);
                    m_active = m_win;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (hrq && validDACK) m_phase = 2;
                else if (!e[m_win]) m_phase = 0;
            end else begin
                if (!validDACK) begin
                    if (rotPriority) m_last = m_win;
                    m_phase = 0;
                end
            end
            void'(pin_hist.pop_front());
            pin_hist.push_back(DREQ);
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model, let the DUT clock, compare on the falling edge
    task automatic tick();
        logic [3:0] exp_valid, exp_dack;
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        exp_valid = (m_phase != 0) ? (4'b0001 << m_win) : 4'b0000;
        exp_dack  = ((m_phase == 2) ? (4'b0001 << m_win) : 4'b0000) ^ {4{~dackSense}};
        check("model_valid", dut_valid, exp_valid);
        check("model_dack", DACK, exp_dack);
        check("model_active", {2'b00, activeCh}, 4'(m_active));
        check("model_busy", {3'b000, busy}, {3'b000, m_phase != 0});
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (dut_valid == 4'b0000 && n < 8) begin
            tick();
            n++;
        end
        total++;
        if (dut_valid == 4'b0000) begin
            bad++;
            $display("FAIL %s: no VALID within 8 cycles (got %b, required nonzero)", name, dut_valid);
        end
    endtask

    task automatic service_one();
        hrq = 1'b1; validDACK = 1'b1;
        tick(); tick();
        hrq = 1'b0; validDACK = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        DREQ = 4'b0000; softReq = 4'b0000; maskReg = 4'b0000;
        dreqSense = 1'b0; dackSense = 1'b0; rotPriority = 1'b0; ctrlDisable = 1'b0;
        hrq = 1'b0; validDACK = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    logic [3:0] rot_exp [4];
    initial begin
        rot_exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset state
        do_reset();
        tick();
        check("reset_dack", DACK, 4'hF);
        check("reset_valid", dut_valid, 4'b0000);
        check("reset_busy", {3'b000, busy}, 4'b0000);

        // Fixed priority: 1010 -> ch1 after three cycles
        DREQ = 4'b1010;
        tick(); tick();
        check("fix_pre_valid", dut_valid, 4'b0000);
        tick();
        check("fix_valid", dut_valid, 4'b0010);
        validDACK = 1'b1;
        tick();
        check("fix_nohrq_dack", DACK, 4'hF);
        hrq = 1'b1;
        tick();
        check("fix_dack", DACK, 4'b1101);
        check("fix_active", {2'b00, activeCh}, 4'd1);
        DREQ = 4'b0000;
        tick(); tick(); tick();
        hrq = 1'b0; validDACK = 1'b0;
        tick();
        check("fix_release", dut_valid, 4'b0000);
        tick(); tick();

        // Rotating then fixed, same stimulus
        for (int mode = 1; mode >= 0; mode--) begin
            do_reset();
            rotPriority = mode[0];
            DREQ = 4'b0010;
            wait_valid("rr_first");
            check("rr_first_valid", dut_valid, 4'b0010);
            DREQ = 4'b0000;
            service_one();
            DREQ = 4'b1111;
            for (int w = 0; w < 4; w++) begin
                wait_valid("rr_wait");
                check(mode == 1 ? "rot_winner" : "fixed_winner", dut_valid,
                      mode == 1 ? rot_exp[w] : 4'b0001);
                service_one();
            end
        end

        // Mask blocks the pin; software request overrides it
        do_reset();
        maskReg = 4'b0001; DREQ = 4'b0001;
        repeat (10) tick();
        check("mask_blocked", dut_valid, 4'b0000);
        softReq = 4'b0001;
        tick();
        check("softreq_valid", dut_valid, 4'b0001);
        softReq = 4'b0000;
        tick();
        check("softreq_withdraw", dut_valid, 4'b0000);

        // Withdraw before grant leaves the rotation pointer alone
        do_reset();
        rotPriority = 1'b1;
        DREQ = 4'b0100;
        wait_valid("wd_wait");
        check("wd_valid", dut_valid, 4'b0100);
        DREQ = 4'b0000;
        tick(); tick(); tick();
        check("wd_cleared", dut_valid, 4'b0000);
        check("wd_busy", {3'b000, busy}, 4'b0000);
        DREQ = 4'b1111;
        wait_valid("wd_next");
        check("wd_next_ch0", dut_valid, 4'b0001);
        DREQ = 4'b0000;
        service_one();
        tick(); tick();

        // Lock during service, active-high DACK
        do_reset();
        dackSense = 1'b1;
        DREQ = 4'b0100;
        wait_valid("lock_wait");
        hrq = 1'b1; validDACK = 1'b1;
        tick();
        check("lock_dack", DACK, 4'b0100);
        DREQ = 4'b0101;
        tick(); tick(); tick();
        check("lock_hold_dack", DACK, 4'b0100);
        check("lock_hold_valid", dut_valid, 4'b0100);
        maskReg = 4'b0100; ctrlDisable = 1'b1;
        tick();
        check("lock_mask_dack", DACK, 4'b0100);
        maskReg = 4'b0000; ctrlDisable = 1'b0; hrq = 1'b0; validDACK = 1'b0;
        tick();
        check("lock_rel_dack", DACK, 4'b0000);
        check("lock_rel_valid", dut_valid, 4'b0000);
        wait_valid("lock_next");
        check("lock_next_ch0", dut_valid, 4'b0001);
        DREQ = 4'b0000;
        tick(); tick(); tick();

        // Reset in the middle of servicing ch3
        do_reset();
        DREQ = 4'b1000;
        wait_valid("rst_wait");
        check("rst_ch3", dut_valid, 4'b1000);
        hrq = 1'b1; validDACK = 1'b1;
        tick(); tick();
        check("rst_dack_pre", DACK, 4'b0111);
        RESET = 1'b1;
        tick();
        RESET = 1'b0; hrq = 1'b0; validDACK = 1'b0;
        check("rst_valid", dut_valid, 4'b0000);
        check("rst_dack", DACK, 4'hF);
        check("rst_busy", {3'b000, busy}, 4'b0000);
        check("rst_active", {2'b00, activeCh}, 4'd0);
        DREQ = 4'b1001;
        wait_valid("rst_next");
        check("rst_next_ch0", dut_valid, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_priority_resolver.md
Name: dma_priority_resolver

Overview:
- Priority resolver for the 8237A-style DMA controller. It is the producer of VALID_DREQ0-3 and the consumer of hrq/validDACK on the control interface.
- Samples external DREQ pins and software requests, applies mask, sense and enable from the command/mask registers, and picks one winning channel (fixed or rotating priority).
- Presents the winner to timing control and drives the DACK pins once timing control reports a valid acknowledge.

Parameters:
- DREQ_SYNC_STAGES, 2, flop stages on DREQ pins (0 = none); adds N cycles of pin-to-VALID latency.
- SOFTREQ_EN, 1, enables the software request register path (0 = softReq ignored).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- DREQ  in  4  external DMA request pins
- softReq  in  4  request register bits (software requests)
- maskReg  in  4  channel mask, 1 = masked
- dreqSense  in  1  command bit 6; 0 = DREQ active high
- dackSense  in  1  command bit 7; 0 = DACK active low
- rotPriority  in  1  command bit 4; 1 = rotating priority
- ctrlDisable  in  1  command bit 2; 1 = no new arbitration
- hrq  in  1  hold request from timing control
- validDACK  in  1  timing control: HLDA received, service in progress
- VALID_DREQ0..VALID_DREQ3  out  1 each  one-hot winning request to timing control
- DACK  out  4  acknowledge pins, polarity per dackSense
- activeCh  out  2  index of latched winner
- busy  out  1  state != IDLE

Behaviour:
- Effective request: eff[i] = ((syncDREQ[i] ^ dreqSense) & ~maskReg[i]) | (SOFTREQ_EN & softReq[i]).
  - softReq ignores mask and bypasses the synchronizer.
  - eff is forced to 0 when ctrlDisable = 1.
- Priority:
  - Fixed: ch0 highest, ch3 lowest.
  - Rotating: lastSvc pointer; order is lastSvc+1, +2, +3, lastSvc (mod 4 wrap).
  - Fixed mode behaves as lastSvc = 3.
- States:
  - IDLE: if any eff, register winner -> REQ; VALID_DREQ[winner] = 1 the next cycle (1 cycle after eff).
  - REQ: VALID_DREQ[winner] held.
    - If eff[winner] = 0 before grant -> withdraw: VALID cleared next cycle, -> IDLE, lastSvc unchanged.
    - If hrq & validDACK -> SERVICE. A validDACK without hrq is ignored.
  - SERVICE: DACK[winner] active starting 1 cycle after the REQ->SERVICE transition.
    - Winner is locked: higher-priority requests, mask changes and ctrlDisable do not preempt.
    - When validDACK = 0: DACK goes inactive and VALID goes to 0 the next cycle; if rotPriority, lastSvc = winner; -> IDLE.
    - A new arbitration may occur in the cycle after return to IDLE.
- Output rules:
  - VALID_DREQ0-3 are always one-hot or all zero, registered.
  - DACK = dackActive (one-hot, registered) XOR {4{~dackSense}}, so inactive pins sit at the idle level.
- Simultaneous events: in REQ, withdraw and grant in the same cycle -> grant wins (SERVICE).
- Reset, synchronous and from any state, including mid-service:
  - state = IDLE, lastSvc = 3, VALID_DREQ0-3 = 0, dackActive = 0, so DACK = 4'hF when dackSense = 0.
  - activeCh = 0, busy = 0, synchronizer flops = 0.

Decomposition:
- dma_pkg:
  - state enum (IDLE, REQ, SERVICE)
  - chan_t (logic [1:0])
  - command-bit index constants (CMD_CTRL_DIS = 2, CMD_ROT = 4, CMD_DREQ_SENSE = 6, CMD_DACK_SENSE = 7)
  - NUM_CH = 4
- Sub-module dma_prio_encoder: combinational; inputs eff[3:0], lastSvc; outputs winner and valid. Unit-testable alone.

Test Plan (DREQ_SYNC_STAGES = 2, so pin-to-VALID = 3 cycles; sense bits 0):
- Fixed priority: DREQ = 4'b1010 from cycle 0 -> VALID_DREQ1 = 1 at cycle 3, others 0. Then hrq = validDACK = 1 -> DACK = 4'b1101 the next cycle, activeCh = 1.
- Rotating: rotPriority = 1, service ch1 to completion, then DREQ = 4'b1111 held -> successive winners 2, 3, 0, 1. Fixed mode with the same stimulus -> always 0.
- Mask and softReq: maskReg = 4'b0001, DREQ = 4'b0001 -> no VALID for 10 cycles. softReq = 4'b0001 -> VALID_DREQ0 after 1 cycle despite the mask.
- Withdraw: DREQ2 asserted then dropped while in REQ, before validDACK -> VALID_DREQ2 clears, busy = 0, next DREQ = 4'b1111 picks ch0 (lastSvc unchanged).
- Lock and sense: dackSense = 1, ch2 in SERVICE, DREQ0 raised -> DACK stays 4'b0100, VALID stays ch2. validDACK drops -> DACK = 0, then ch0 wins.
- Reset mid-service: RESET for 1 cycle during SERVICE of ch3 -> next edge all VALID 0, DACK = 4'hF, busy = 0, fixed order restored.
